// File: rtl/ppu_pkg.sv
// ppu_pkg: OAM byte layout, attribute read mask and evaluator state type
package ppu_pkg;
  localparam int OAM_Y = 0;
  localparam int OAM_TILE = 1;
  localparam int OAM_ATTR = 2;
  localparam int OAM_X = 3;
  localparam int SPR_BYTES = 4;
  localparam logic [7:0] OAM_ATTR_MASK = 8'hE3;
  typedef enum logic [1:0] {IDLE, CLEAR, EVAL, DONE} eval_state_t;
endpackage

// File: rtl/oam_ram.sv
// oam_ram: byte-wide RAM with one write port and one registered read port
module oam_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= RST_VAL;
    else rdata <= mem[raddr];
endmodule

// File: rtl/sprite_eval.sv
// sprite_eval: primary OAM with CPU/DMA write path and a per-scanline
// evaluator that copies in-range sprites into secondary OAM.
module sprite_eval
  import ppu_pkg::*;
#(
  parameter int NUM_SPR = 64,
  parameter int MAX_SPR = 8,
  parameter int PA_W = $clog2(NUM_SPR * 4),
  parameter int SA_W = $clog2(MAX_SPR * 4),
  parameter int CNT_W = $clog2(MAX_SPR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oam_addr_we,
  input  logic             oam_data_we,
  input  logic [7:0]       cpu_data_i,
  input  logic             dma_we,
  input  logic [7:0]       dma_data,
  output logic [7:0]       oam_rdata_o,
  input  logic             eval_start,
  input  logic [8:0]       scanline,
  input  logic             spr_h16,
  output logic             busy,
  output logic             eval_done,
  output logic [CNT_W-1:0] spr_count,
  output logic             spr0_in,
  output logic             spof_s,
  input  logic [SA_W-1:0]  sec_addr,
  output logic [7:0]       sec_data
);
  localparam int N_W = PA_W - 2;
  localparam int SEC_BYTES = MAX_SPR * SPR_BYTES;
  eval_state_t state_q, state_d;
  logic [8:0] line_q, line_d, diff;
  logic h16_q, h16_d, busy_q, busy_d, done_q, done_d, spof_q, spof_d, spr0_q, spr0_d;
  logic rd_busy_q, rd_attr_q, in_range, wr, pri_we, sec_we, adv;
  logic [N_W-1:0] n_q, n_d;
  logic [2:0] ph_q, ph_d;
  logic [SA_W-1:0] clr_q, clr_d, sec_waddr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0] slot;
  logic [PA_W-1:0] oa_q, oa_d, pri_addr;
  logic [1:0] off;
  logic [7:0] pri_rdata, pri_wdata, sec_wdata, rdata_q, rdata_d;
  // DMA wins a collision with a CPU write; either one advances OAMADDR once
  assign wr = dma_we | oam_data_we;
  assign pri_we = wr & ~busy_q;
  assign pri_wdata = dma_we ? dma_data : cpu_data_i;
  assign oa_d = oam_addr_we ? cpu_data_i[PA_W-1:0] : wr ? oa_q + PA_W'(1) : oa_q;
  assign off = ph_q == 3'd1 ? 2'(OAM_TILE) : ph_q == 3'd2 ? 2'(OAM_ATTR) :
               ph_q == 3'd3 ? 2'(OAM_X) : 2'(OAM_Y);
  assign pri_addr = busy_q ? {n_q, off} : oa_q;
  assign diff = line_q - {1'b0, pri_rdata};
  assign in_range = line_q >= {1'b0, pri_rdata} && diff < (h16_q ? 9'd16 : 9'd8);
  assign slot = {cnt_q, 2'b00} + (CNT_W + 2)'(ph_q - 3'd1);
  assign sec_waddr = state_q == CLEAR ? clr_q : SA_W'(slot);
  assign sec_wdata = state_q == CLEAR ? 8'hFF : pri_rdata;
  assign rdata_d = (busy_q | rd_busy_q) ? 8'hFF : rd_attr_q ? pri_rdata & OAM_ATTR_MASK : pri_rdata;
  // Phase 0 fetches Y, phase 1 compares; phases 1..4 stream Y/tile/attr/X on a hit
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    h16_d = h16_q;
    cnt_d = cnt_q;
    spr0_d = spr0_q;
    n_d = n_q;
    ph_d = ph_q;
    clr_d = clr_q;
    spof_d = 1'b0;
    sec_we = 1'b0;
    adv = 1'b0;
    case (state_q)
      IDLE: if (eval_start) begin
        state_d = CLEAR;
        line_d = scanline;
        h16_d = spr_h16;
        cnt_d = '0;
        spr0_d = 1'b0;
        n_d = '0;
        ph_d = '0;
        clr_d = '0;
      end
      CLEAR: begin
        sec_we = 1'b1;
        clr_d = clr_q + SA_W'(1);
        if (clr_q == SA_W'(SEC_BYTES - 1)) state_d = EVAL;
      end
      EVAL: begin
        if (ph_q == 3'd0) ph_d = 3'd1;
        else if (ph_q == 3'd1) begin
          if (!in_range) adv = 1'b1;
          else if (cnt_q == CNT_W'(MAX_SPR)) begin
            spof_d = 1'b1;
            state_d = DONE;
          end else begin
            sec_we = 1'b1;
            ph_d = 3'd2;
          end
        end else begin
          sec_we = 1'b1;
          ph_d = ph_q + 3'd1;
          if (ph_q == 3'd4) begin
            cnt_d = cnt_q + CNT_W'(1);
            spr0_d = spr0_q | (n_q == '0);
            adv = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
    if (adv) begin
      ph_d = '0;
      if (n_q == N_W'(NUM_SPR - 1)) state_d = DONE;
      else n_d = n_q + N_W'(1);
    end
    busy_d = state_d == CLEAR || state_d == EVAL;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      h16_q <= 1'b0;
      cnt_q <= '0;
      spr0_q <= 1'b0;
      n_q <= '0;
      ph_q <= '0;
      clr_q <= '0;
      spof_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      oa_q <= '0;
      rd_busy_q <= 1'b0;
      rd_attr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      h16_q <= h16_d;
      cnt_q <= cnt_d;
      spr0_q <= spr0_d;
      n_q <= n_d;
      ph_q <= ph_d;
      clr_q <= clr_d;
      spof_q <= spof_d;
      busy_q <= busy_d;
      done_q <= done_d;
      oa_q <= oa_d;
      rd_busy_q <= busy_q;
      rd_attr_q <= oa_q[1:0] == 2'(OAM_ATTR);
      rdata_q <= rdata_d;
    end
  assign busy = busy_q;
  assign eval_done = done_q;
  assign spof_s = spof_q;
  assign spr_count = cnt_q;
  assign spr0_in = spr0_q;
  assign oam_rdata_o = rdata_q;
  oam_ram #(.DEPTH(NUM_SPR * SPR_BYTES), .AW(PA_W), .RST_VAL(8'h00)) u_pri (
    .clk(clk), .rst(rst), .we(pri_we), .waddr(pri_addr), .raddr(pri_addr),
    .wdata(pri_wdata), .rdata(pri_rdata)
  );
  oam_ram #(.DEPTH(SEC_BYTES), .AW(SA_W), .RST_VAL(8'hFF)) u_sec (
    .clk(clk), .rst(rst), .we(sec_we), .waddr(sec_waddr), .raddr(sec_addr),
    .wdata(sec_wdata), .rdata(sec_data)
  );
endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: scoreboard bench for sprite_eval against a behavioural OAM model
module tb_sprite_eval;
  localparam int NSPR = 64, MAXS = 8, NB = NSPR * 4;
  typedef struct { int cnt; int spr0; int ovf; int lat; int st; } ev_t;
  logic clk = 0, rst = 1;
  logic oam_addr_we = 0, oam_data_we = 0, dma_we = 0, eval_start = 0, spr_h16 = 0;
  logic [7:0] cpu_data_i = 0, dma_data = 0, oam_rdata_o, sec_data;
  logic [8:0] scanline = 0;
  logic busy, eval_done, spr0_in, spof_s;
  logic [3:0] spr_count;
  logic [4:0] sec_addr = 0;
  logic sr_req = 0, sr_v = 0, pr_req = 0, pr_v = 0;
  int cyc = 0, chk_n = 0, err_n = 0, ndone = 0, spof_n = 0, oa = 0;
  logic [7:0] pri [NB];
  logic [7:0] exp_sec [MAXS * 4];
  logic [7:0] sec_q [$];
  logic [7:0] pr_q [$];
  ev_t ev_q [$];
  ev_t e, em;

  sprite_eval #(.NUM_SPR(NSPR), .MAX_SPR(MAXS)) dut (
    .clk(clk), .rst(rst), .oam_addr_we(oam_addr_we), .oam_data_we(oam_data_we),
    .cpu_data_i(cpu_data_i), .dma_we(dma_we), .dma_data(dma_data), .oam_rdata_o(oam_rdata_o),
    .eval_start(eval_start), .scanline(scanline), .spr_h16(spr_h16), .busy(busy),
    .eval_done(eval_done), .spr_count(spr_count), .spr0_in(spr0_in), .spof_s(spof_s),
    .sec_addr(sec_addr), .sec_data(sec_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr_v <= sr_req;
    pr_v <= pr_req;
  end

  task automatic chk(input string nm, input int act, input int exp);
    chk_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (spof_s) spof_n++;
    if (eval_done) begin
      ndone++;
      if (ev_q.size() == 0) chk("eval_done_expected", 0, 1);
      else begin
        em = ev_q.pop_front();
        chk("spr_count", int'(spr_count), em.cnt);
        chk("spr0_in", int'(spr0_in), em.spr0);
        chk("spof_pulses", spof_n, em.ovf);
        chk("eval_latency", cyc - em.st - 1, em.lat);
      end
      spof_n = 0;
    end
    if (sr_v) begin
      if (sec_q.size() == 0) chk("sec_expected", 0, 1);
      else chk("sec_data", int'(sec_data), int'(sec_q.pop_front()));
    end
    if (pr_v) begin
      if (pr_q.size() == 0) chk("oam_expected", 0, 1);
      else chk("oam_rdata", int'(oam_rdata_o), int'(pr_q.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_addr(input int a);
    oam_addr_we = 1;
    cpu_data_i = 8'(a);
    tick();
    oam_addr_we = 0;
    oa = a & (NB - 1);
  endtask

  task automatic cpu_wr(input logic [7:0] d, input bit drop);
    oam_data_we = 1;
    cpu_data_i = d;
    tick();
    oam_data_we = 0;
    if (!drop) pri[oa] = d;
    oa = (oa + 1) & (NB - 1);
  endtask

  task automatic dma_wr(input logic [7:0] d, input bit drop);
    dma_we = 1;
    dma_data = d;
    tick();
    dma_we = 0;
    if (!drop) pri[oa] = d;
    oa = (oa + 1) & (NB - 1);
  endtask

  task automatic fill_all(input int y);
    set_addr(0);
    for (int i = 0; i < NB; i++) dma_wr(i % 4 == 0 ? 8'(y) : 8'($urandom_range(0, 255)), 0);
  endtask

  task automatic write_y(input int n, input int y);
    set_addr(n * 4);
    dma_wr(8'(y), 0);
  endtask

  task automatic read_cur();
    tick();
    pr_q.push_back(oa % 4 == 2 ? pri[oa] & 8'hE3 : pri[oa]);
    pr_req = 1;
    tick();
    pr_req = 0;
  endtask

  // Reference: scan sprites in order, keep the first MAXS hits, stop on the next
  task automatic model_eval(input int line, input bit h16);
    int h;
    h = h16 ? 16 : 8;
    e = '{cnt: 0, spr0: 0, ovf: 0, lat: MAXS * 4, st: 0};
    foreach (exp_sec[i]) exp_sec[i] = 8'hFF;
    for (int n = 0; n < NSPR; n++) begin
      int y;
      y = int'(pri[n * 4]);
      if (line >= y && line - y < h) begin
        if (e.cnt == MAXS) begin
          e.ovf = 1;
          e.lat += 2;
          break;
        end
        for (int k = 0; k < 4; k++) exp_sec[e.cnt * 4 + k] = pri[n * 4 + k];
        if (n == 0) e.spr0 = 1;
        e.cnt++;
        e.lat += 5;
      end else e.lat += 2;
    end
  endtask

  task automatic start_eval(input int line, input bit h16);
    model_eval(line, h16);
    e.st = cyc;
    ev_q.push_back(e);
    scanline = 9'(line);
    spr_h16 = h16;
    eval_start = 1;
    tick();
    eval_start = 0;
  endtask

  task automatic finish_eval();
    int prev;
    prev = ndone;
    for (int i = 0; i < 400 && ndone == prev; i++) tick();
    if (ndone == prev) begin
      chk("eval_done_timeout", 0, 1);
      void'(ev_q.pop_front());
    end
    tick();
    for (int a = 0; a < MAXS * 4; a++) begin
      sec_addr = 5'(a);
      sec_q.push_back(exp_sec[a]);
      sr_req = 1;
      tick();
    end
    sr_req = 0;
    tick();
  endtask

  task automatic run_eval(input int line, input bit h16);
    start_eval(line, h16);
    finish_eval();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_eval_done", int'(eval_done), 0);
    chk("rst_spof", int'(spof_s), 0);
    chk("rst_spr0", int'(spr0_in), 0);
    chk("rst_count", int'(spr_count), 0);
    chk("rst_oam_rdata", int'(oam_rdata_o), 0);
    chk("rst_sec_data", int'(sec_data), 8'hFF);
    rst = 0;
    tick();
    fill_all(8'hF0);
    set_addr(2);
    cpu_wr(8'hFF, 0);
    read_cur();
    set_addr(2);
    read_cur();
    set_addr(7);
    oam_data_we = 1;
    cpu_data_i = 8'h11;
    dma_we = 1;
    dma_data = 8'h22;
    tick();
    oam_data_we = 0;
    dma_we = 0;
    pri[7] = 8'h22;
    oa = 8;
    read_cur();
    set_addr(7);
    read_cur();
    set_addr(12);
    oam_addr_we = 1;
    cpu_data_i = 8'd20;
    dma_we = 1;
    dma_data = 8'h77;
    tick();
    oam_addr_we = 0;
    dma_we = 0;
    pri[12] = 8'h77;
    oa = 20;
    read_cur();
    set_addr(12);
    read_cur();
    fill_all(8'hF0);
    write_y(0, 10);
    write_y(5, 10);
    run_eval(12, 0);
    scanline = 9'd12;
    spr_h16 = 0;
    eval_start = 1;
    tick();
    eval_start = 0;
    repeat (MAXS * 4 + 20) tick();
    chk("busy_mid_eval", int'(busy), 1);
    chk("count_mid_nonzero", int'(spr_count != 0), 1);
    rst = 1;
    #1;
    chk("busy_after_async_rst", int'(busy), 0);
    chk("count_after_async_rst", int'(spr_count), 0);
    chk("spr0_after_async_rst", int'(spr0_in), 0);
    tick();
    rst = 0;
    oa = 0;
    tick();
    run_eval(12, 0);
    write_y(0, 8'hF0);
    write_y(5, 8'hF0);
    write_y(3, 100);
    run_eval(110, 0);
    run_eval(110, 1);
    run_eval(116, 1);
    run_eval(115, 1);
    run_eval(107, 0);
    run_eval(108, 0);
    write_y(3, 250);
    run_eval(260, 1);
    for (int i = 0; i < 9; i++) write_y(i, 50);
    run_eval(50, 0);
    run_eval(57, 1);
    set_addr(9);
    start_eval(50, 0);
    repeat (3) tick();
    cpu_wr(8'h5A, 1);
    chk("oam_rdata_busy", int'(oam_rdata_o), 8'hFF);
    dma_wr(8'hA5, 1);
    finish_eval();
    read_cur();
    set_addr(9);
    read_cur();
    repeat (6) begin
      int line;
      bit h16;
      line = $urandom_range(0, 239);
      h16 = 1'($urandom_range(0, 1));
      set_addr(0);
      for (int i = 0; i < NB; i++)
        dma_wr(i % 4 != 0 ? 8'($urandom_range(0, 255)) :
               $urandom_range(0, 3) == 0 ? 8'(line - $urandom_range(0, 17)) : 8'($urandom_range(0, 255)), 0);
      run_eval(line, h16);
    end
    repeat (3) tick();
    chk("eval_queue_drained", ev_q.size(), 0);
    chk("sec_queue_drained", sec_q.size(), 0);
    chk("oam_queue_drained", pr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end
endmodule
